udp_tx_sched: RTL and testbench



---
 rtl/udp_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_udp_tx_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// udp_tx_sched: two-channel round-robin scheduler in front of the UDP TX engine.
// Optional SEND watchdog enabled by defining UDP_SCHED_TIMEOUT_EN.
module udp_tx_sched #(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] byte_num0,
    input  logic [15:0] byte_num1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        rd0,
    output logic        rd1,
    output logic        done0,
    output logic        done1,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [31:0] tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        err
);

    localparam int          GAP_LEN  = (IFG_CYCLES < 2) ? 2 : IFG_CYCLES;
    localparam logic [15:0] GAP_LAST = 16'(GAP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [15:0] bytes_q, bytes_d;
    logic        rr_q, rr_d;
    logic [1:0]  done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] gap_q, gap_d;
    logic        win1;
    logic [15:0] win_bytes;

`ifdef UDP_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_q, to_d;
`endif

    // Channel 1 wins when alone, or when both ask and the pointer favours it.
    assign win1      = req1 & (~req0 | rr_q);
    assign win_bytes = win1 ? byte_num1 : byte_num0;

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            bytes_q <= 16'd0;
            rr_q    <= 1'b0;
            done_q  <= 2'b00;
            err_q   <= 1'b0;
            gap_q   <= 16'd0;
`ifdef UDP_SCHED_TIMEOUT_EN
            to_q    <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            bytes_q <= bytes_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
`ifdef UDP_SCHED_TIMEOUT_EN
            to_q    <= to_d;
`endif
        end
    end

    // Next-state logic: arbitration, completion and inter-packet gap.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        bytes_d = bytes_q;
        rr_d    = rr_q;
        done_d  = 2'b00;
        err_d   = 1'b0;
        gap_d   = gap_q;
`ifdef UDP_SCHED_TIMEOUT_EN
        to_d    = to_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    rr_d    = ~win1;
                    bytes_d = win_bytes;
                    if (win_bytes == 16'd0) begin
                        done_d  = win1 ? 2'b10 : 2'b01;
                        grant_d = 2'b00;
                        gap_d   = 16'd0;
                        state_d = S_GAP;
                    end else begin
                        grant_d = win1 ? 2'b10 : 2'b01;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_SEND;
`ifdef UDP_SCHED_TIMEOUT_EN
                to_d    = 16'd0;
`endif
            end
            S_SEND: begin
                if (tx_done) begin
                    done_d  = grant_q;
                    grant_d = 2'b00;
                    gap_d   = 16'd0;
                    state_d = S_GAP;
                end
`ifdef UDP_SCHED_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    done_d  = grant_q;
                    grant_d = 2'b00;
                    gap_d   = 16'd0;
                    state_d = S_GAP;
                end else begin
                    to_d = to_q + 16'd1;
                end
`endif
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_start_en = (state_q == S_START);
    assign busy        = (state_q != S_IDLE);
    assign tx_byte_num = bytes_q;
    assign grant       = grant_q;
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign rd0         = (state_q == S_SEND) & tx_req & grant_q[0];
    assign rd1         = (state_q == S_SEND) & tx_req & grant_q[1];
    assign tx_data     = grant_q[1] ? data1 :
                         grant_q[0] ? data0 : 32'd0;
`ifdef UDP_SCHED_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb_udp_tx_sched: scoreboard bench for udp_tx_sched.
// Expected start/done events are queued by stimulus, popped by the monitor.
module tb_udp_tx_sched;

    localparam int G = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [15:0] byte_num0, byte_num1;
    logic [31:0] data0, data1;
    logic        rd0, rd1, done0, done1, tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        tx_req, tx_done;
    logic [1:0]  grant;
    logic        busy, err;

    udp_tx_sched #(
        .IFG_CYCLES    (G),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .byte_num0  (byte_num0),
        .byte_num1  (byte_num1),
        .data0      (data0),
        .data1      (data1),
        .rd0        (rd0),
        .rd1        (rd1),
        .done0      (done0),
        .done1      (done1),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .tx_done    (tx_done),
        .grant      (grant),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = -1000;
    logic [17:0] sq[$];
    logic [2:0]  dq[$];
    bit pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx_start_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("start_timeout");
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        if (!idle) fail("idle_timeout");
    endtask

    // Monitor: compare every start and done event against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_start = -1000;
        end else begin
            if (tx_start_en) begin
                if (sq.size() == 0) fail("start_unexpected");
                else chk("start_grant_bytes", {14'd0, grant, tx_byte_num},
                         {14'd0, sq.pop_front()});
                chk("start_spacing", {31'd0, (cyc - last_start) >= 14}, 1);
                last_start = cyc;
            end
            if (done0 | done1) begin
                if (dq.size() == 0) fail("done_unexpected");
                else chk("done_err_vec", {29'd0, err, done1, done0},
                         {29'd0, dq.pop_front()});
            end
        end
    end

    initial begin
        bit ok;
        int d;
        int s;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        byte_num0 = 16'd0; byte_num1 = 16'd0;
        data0 = 32'h1111_0000; data1 = 32'h2222_0000;
        tx_req = 1'b1; tx_done = 1'b1;
        tick(); tick();
        chk("reset_grant", {30'd0, grant}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_bytes", {16'd0, tx_byte_num}, 0);
        chk("reset_start", {31'd0, tx_start_en}, 0);
        chk("reset_done", {30'd0, done1, done0}, 0);
        chk("reset_err", {31'd0, err}, 0);
        chk("reset_rd", {30'd0, rd1, rd0}, 0);
        chk("reset_data", tx_data, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_spurious_rd", {30'd0, rd1, rd0}, 0);
        tick();
        chk("idle_spurious_busy", {31'd0, busy}, 0);
        tx_req = 1'b0; tx_done = 1'b0;
        tick();

        // Single request on channel 0.
        req0 = 1'b1; byte_num0 = 16'd100;
        sq.push_back({2'b01, 16'd100});
        tick();
        chk("t1_start", {31'd0, tx_start_en}, 1);
        chk("t1_grant", {30'd0, grant}, 32'h1);
        chk("t1_bytes", {16'd0, tx_byte_num}, 100);
        chk("t1_busy", {31'd0, busy}, 1);
        tick();
        chk("t1_start_once", {31'd0, tx_start_en}, 0);
        data0 = 32'hA0A0_0001; data1 = 32'hB1B1_0001; tx_req = 1'b1;
        #1;
        chk("t1_rd0", {31'd0, rd0}, 1);
        chk("t1_data", tx_data, 32'hA0A0_0001);
        repeat (5) tick();
        tx_req = 1'b0; tx_done = 1'b1;
        dq.push_back(3'b001);
        tick();
        tx_done = 1'b0; req0 = 1'b0;
        chk("t1_done0", {31'd0, done0}, 1);
        chk("t1_grant_clr", {30'd0, grant}, 0);
        chk("t1_busy_gap", {31'd0, busy}, 1);
        chk("t1_bytes_hold", {16'd0, tx_byte_num}, 100);
        repeat (12) tick();
        chk("t1_busy_low", {31'd0, busy}, 0);

        // Steering with channel 1 granted.
        req1 = 1'b1; byte_num1 = 16'd40;
        sq.push_back({2'b10, 16'd40});
        tick();
        chk("t2_grant", {30'd0, grant}, 32'h2);
        tick();
        for (int i = 0; i < 4; i++) begin
            tx_req = pat[i];
            data1 = 32'hD000_0000 + i;
            data0 = 32'hE000_0000 + i;
            #1;
            chk("t2_rd1", {31'd0, rd1}, {31'd0, pat[i]});
            chk("t2_rd0", {31'd0, rd0}, 0);
            chk("t2_data", tx_data, 32'hD000_0000 + i);
            tick();
        end
        tx_req = 1'b0; tx_done = 1'b1;
        dq.push_back(3'b010);
        tick();
        tx_done = 1'b0; req1 = 1'b0;
        chk("t2_done1", {31'd0, done1}, 1);
        wait_idle();

        // Zero-length drop on channel 1, then a gap-delayed channel 0.
        req1 = 1'b1; byte_num1 = 16'd0;
        dq.push_back(3'b010);
        tick();
        chk("t3_done1", {31'd0, done1}, 1);
        chk("t3_no_start", {31'd0, tx_start_en}, 0);
        chk("t3_grant", {30'd0, grant}, 0);
        chk("t3_busy", {31'd0, busy}, 1);
        d = cyc;
        req1 = 1'b0; req0 = 1'b1; byte_num0 = 16'd7;
        sq.push_back({2'b01, 16'd7});
        wait_start(ok);
        if (ok) chk("t3_gap_len", cyc - d, G + 1);
        tick();
        tx_done = 1'b1;
        dq.push_back(3'b001);
        tick();
        tx_done = 1'b0; req0 = 1'b0;
        wait_idle();

        // Watchdog behaviour.
        req0 = 1'b1; byte_num0 = 16'd5;
        sq.push_back({2'b01, 16'd5});
        wait_start(ok);
        tick();
        s = cyc;
`ifdef UDP_SCHED_TIMEOUT_EN
        dq.push_back(3'b101);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("t4_timeout_missing");
        else begin
            chk("t4_to_cycles", cyc - s, 50);
            chk("t4_err", {31'd0, err}, 1);
            chk("t4_grant", {30'd0, grant}, 0);
        end
        req0 = 1'b0;
        wait_idle();
`else
        ok = 1'b1;
        repeat (200) begin
            tick();
            if (!busy) ok = 1'b0;
        end
        chk("t4_busy_hold", {31'd0, ok}, 1);
        chk("t4_send_len", cyc - s, 200);
        tx_done = 1'b1;
        dq.push_back(3'b001);
        tick();
        tx_done = 1'b0; req0 = 1'b0;
        chk("t4_err", {31'd0, err}, 0);
        wait_idle();
`endif

        // Mid-packet reset, then contention from reset.
        req0 = 1'b1; byte_num0 = 16'd20;
        sq.push_back({2'b01, 16'd20});
        wait_start(ok);
        tick();
        tx_req = 1'b1; rst_n = 1'b0;
        tick();
        chk("r_grant", {30'd0, grant}, 0);
        chk("r_busy", {31'd0, busy}, 0);
        chk("r_bytes", {16'd0, tx_byte_num}, 0);
        chk("r_start", {31'd0, tx_start_en}, 0);
        chk("r_done", {30'd0, done1, done0}, 0);
        chk("r_rd", {30'd0, rd1, rd0}, 0);
        tx_req = 1'b0; rst_n = 1'b1;
        req1 = 1'b1; byte_num0 = 16'd30; byte_num1 = 16'd31;
        for (int k = 0; k < 4; k++) begin
            sq.push_back((k % 2 == 0) ? {2'b01, 16'd30} : {2'b10, 16'd31});
            dq.push_back((k % 2 == 0) ? 3'b001 : 3'b010);
        end
        for (int k = 0; k < 4; k++) begin
            wait_start(ok);
            if (!ok) break;
            chk("c_order", {30'd0, grant}, (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            repeat (3) begin
                tx_req = ~tx_req;
                tick();
            end
            tx_req = 1'b0; tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;
        wait_idle();
        tick();
        chk("sq_empty", sq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
